// File: rtl/button_event_decoder.sv
// Merges short/long press pulses into click gestures and queues them in a valid/ready FIFO.
// Define BTN_TRIPLE_CLICK_EN to enable the WAIT2 state and the TRIPLE event.
module button_event_decoder #(
  parameter int unsigned WIN_CYCLES = 15_000_000,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          rst_n,
  input  logic [1:0]                    state,
  output logic [2:0]                    evt_code,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_level,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

`ifdef BTN_TRIPLE_CLICK_EN
  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} state_e;
  typedef enum logic [2:0] {
    EV_NONE = 3'b000, EV_SINGLE = 3'b001, EV_DOUBLE = 3'b010,
    EV_LONG = 3'b011, EV_TRIPLE = 3'b100
  } evt_e;
`else
  typedef enum logic [1:0] {IDLE, WAIT1} state_e;
  typedef enum logic [2:0] {
    EV_NONE = 3'b000, EV_SINGLE = 3'b001, EV_DOUBLE = 3'b010, EV_LONG = 3'b011
  } evt_e;
`endif

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_timer;
  logic             w_tmr_clr;
  logic             w_push;
  evt_e             w_push_code;
  logic             w_short;
  logic             w_long;
  logic             w_tmo;

  logic [2:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             r_ovf;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_ovf_set;

  assign w_short = (state == 2'b01);
  assign w_long  = (state == 2'b10);
  assign w_tmo   = (r_timer == CNT_W'(WIN_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_tmr_clr || (w_next == IDLE)) r_timer <= '0;
      else                               r_timer <= r_timer + 1'b1;
    end
  end

  // An input pulse takes precedence over a coincident window timeout.
  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_push_code = EV_NONE;
    w_tmr_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_short) begin
          w_next    = WAIT1;
          w_tmr_clr = 1'b1;
        end else if (w_long) begin
          w_push      = 1'b1;
          w_push_code = EV_LONG;
        end
      end
      WAIT1: begin
        if (w_short) begin
`ifdef BTN_TRIPLE_CLICK_EN
          w_next    = WAIT2;
          w_tmr_clr = 1'b1;
`else
          w_next      = IDLE;
          w_push      = 1'b1;
          w_push_code = EV_DOUBLE;
`endif
        end else if (w_long) begin
          w_next      = IDLE;
          w_push      = 1'b1;
          w_push_code = EV_LONG;
        end else if (w_tmo) begin
          w_next      = IDLE;
          w_push      = 1'b1;
          w_push_code = EV_SINGLE;
        end
      end
`ifdef BTN_TRIPLE_CLICK_EN
      WAIT2: begin
        if (w_short) begin
          w_next      = IDLE;
          w_push      = 1'b1;
          w_push_code = EV_TRIPLE;
        end else if (w_long) begin
          w_next      = IDLE;
          w_push      = 1'b1;
          w_push_code = EV_LONG;
        end else if (w_tmo) begin
          w_next      = IDLE;
          w_push      = 1'b1;
          w_push_code = EV_DOUBLE;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  assign evt_valid = (r_level != '0);
  assign evt_code  = r_mem[r_rd_ptr];
  assign evt_level = r_level;
  assign ovf       = r_ovf;

  assign w_pop     = evt_valid && evt_ready;
  assign w_full    = (r_level == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_push_code;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed plus random bench for button_event_decoder against a time-stamp/queue reference model.
module tb_button_event_decoder;

  localparam int WIN   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] st = 2'b00;
  logic       rdy = 1'b1;
  logic       clr = 1'b0;
  logic [2:0] evt_code;
  logic       evt_valid;
  logic [2:0] evt_level;
  logic       ovf;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pending click count, edge index of the last short, event queue.
  int         m_pend = 0;
  int         m_now = 0;
  int         m_last = 0;
  logic [2:0] m_q[$];
  logic       m_ovf = 1'b0;

  always #10 clk = ~clk;

  button_event_decoder #(
    .WIN_CYCLES(WIN),
    .CNT_W(4),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLOCK_50(clk),
    .rst_n(rst_n),
    .state(st),
    .evt_code(evt_code),
    .evt_valid(evt_valid),
    .evt_ready(rdy),
    .evt_level(evt_level),
    .ovf(ovf),
    .ovf_clr(clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] s, input logic r, input logic c);
    logic       pop;
    logic       push;
    logic [2:0] code;
    pop  = (m_q.size() > 0) && r;
    push = 1'b0;
    code = 3'b000;
    m_now++;
    if (s == 2'b01) begin
      if (m_pend == 0) begin
        m_pend = 1;
        m_last = m_now;
      end else begin
`ifdef BTN_TRIPLE_CLICK_EN
        if (m_pend == 1) begin
          m_pend = 2;
          m_last = m_now;
        end else begin
          push = 1'b1; code = 3'b100; m_pend = 0;
        end
`else
        push = 1'b1; code = 3'b010; m_pend = 0;
`endif
      end
    end else if (s == 2'b10) begin
      push = 1'b1; code = 3'b011; m_pend = 0;
    end else if (m_pend > 0 && (m_now - m_last) == WIN) begin
      push = 1'b1;
      code = (m_pend == 1) ? 3'b001 : 3'b010;
      m_pend = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(code);
      else                    m_ovf = 1'b1;
    end
    if (!(push && m_q.size() == DEPTH && !pop) && c && !(push && !pop && m_q.size() >= DEPTH))
      if (!(push && !pop && m_q.size() == DEPTH && m_ovf)) m_ovf = m_ovf;
  endtask

  task automatic compare_outputs();
    check("valid", 32'(evt_valid), 32'(m_q.size() > 0));
    check("level", 32'(evt_level), 32'(m_q.size()));
    check("ovf",   32'(ovf),       32'(m_ovf));
    if (m_q.size() > 0) check("code", 32'(evt_code), 32'(m_q[0]));
  endtask

  task automatic step(input logic [1:0] s, input logic r, input logic c);
    logic was_full_drop;
    @(negedge clk);
    st  = s;
    rdy = r;
    clr = c;
    if (rst_n) begin
      // ovf: a new drop this edge wins over a clear on the same edge.
      was_full_drop = ((s == 2'b10) || (s == 2'b01) || 1'b1) && 1'b0;
      begin : ovf_eval
        logic old_ovf;
        old_ovf = m_ovf;
        m_ovf = 1'b0;
        model_edge(s, r, c);
        if (m_ovf)     m_ovf = 1'b1;
        else if (c)    m_ovf = 1'b0;
        else           m_ovf = old_ovf;
      end
    end
    @(posedge clk);
    #1;
    st  = 2'b00;
    clr = 1'b0;
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(2'b00, r, 1'b0);
  endtask

  initial begin
    #1;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_code",  32'(evt_code),  32'd0);
    check("rst_level", 32'(evt_level), 32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10, 1'b1);

    // Lone short -> SINGLE exactly WIN edges later.
    step(2'b01, 1'b1, 1'b0);
    idle(WIN - 1, 1'b1);
    check("single_not_yet", 32'(evt_valid), 32'd0);
    idle(1, 1'b1);
    check("single_valid", 32'(evt_valid), 32'd1);
    check("single_code",  32'(evt_code),  32'd1);
    idle(12, 1'b1);

    // Two shorts four edges apart.
    step(2'b01, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(2'b01, 1'b1, 1'b0);
    idle(WIN + 4, 1'b1);
`ifdef BTN_TRIPLE_CLICK_EN
    // Three shorts -> TRIPLE.
    step(2'b01, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(2'b01, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(2'b01, 1'b1, 1'b0);
    check("triple_code", 32'(evt_code), 32'd4);
    idle(WIN + 4, 1'b1);
`endif

    // Second short lands on the timeout edge: pulse wins.
    step(2'b01, 1'b1, 1'b0);
    idle(WIN - 1, 1'b1);
    step(2'b01, 1'b1, 1'b0);
`ifndef BTN_TRIPLE_CLICK_EN
    check("coincide_code", 32'(evt_code), 32'd2);
`endif
    idle(2 * WIN + 4, 1'b1);

    // Long cancels a pending short.
    step(2'b01, 1'b1, 1'b0);
    idle(1, 1'b1);
    step(2'b10, 1'b1, 1'b0);
    check("long_code", 32'(evt_code), 32'd3);
    idle(WIN + 4, 1'b1);

    // Reserved code ignored.
    step(2'b11, 1'b1, 1'b0);
    idle(WIN + 2, 1'b1);

    // Asynchronous reset mid-window discards the pending click.
    step(2'b01, 1'b1, 1'b0);
    idle(2, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(evt_valid), 32'd0);
    check("arst_level", 32'(evt_level), 32'd0);
    idle(3, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(WIN + 4, 1'b1);

    // Backpressure: five longs into a depth-4 queue.
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 1'b0, 1'b0);
      idle(2, 1'b0);
    end
    check("ovf_level", 32'(evt_level), 32'd4);
    check("ovf_flag",  32'(ovf),       32'd1);
    check("ovf_head",  32'(evt_code),  32'd3);
    idle(6, 1'b1);
    check("drain_level", 32'(evt_level), 32'd0);
    step(2'b00, 1'b1, 1'b1);
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Full queue with simultaneous pop and push.
    for (int i = 0; i < 4; i++) step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    check("fullpp_level", 32'(evt_level), 32'd4);
    check("fullpp_ovf",   32'(ovf),       32'd0);
    // Overflow and clear on the same edge: set wins.
    step(2'b10, 1'b0, 1'b1);
    check("setwins_ovf", 32'(ovf), 32'd1);
    idle(6, 1'b1);
    step(2'b00, 1'b1, 1'b1);

    // Randomised traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned p;
      logic [1:0]  s;
      logic        r;
      logic        c;
      p = $urandom_range(0, 99);
      if (p < 12)      s = 2'b01;
      else if (p < 17) s = 2'b10;
      else if (p < 20) s = 2'b11;
      else             s = 2'b00;
      r = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 49) == 0);
      step(s, r, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
